// File: rtl/stump_biu_if.sv
// Core-side and memory-side signals of the Stump bus interface unit.
// The master modport is the BIU itself; the slave modport is the core/memory environment.
interface stump_biu_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              cpu_ren;
    logic              cpu_wen;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              cpu_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic [1:0]        dbg_state;

    modport master (
        input  cpu_ren, cpu_wen, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        output cpu_rdata, cpu_stall, cpu_err, mem_req, mem_we, mem_addr, mem_wdata,
        output dbg_state
    );

    modport slave (
        output cpu_ren, cpu_wen, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        input  cpu_rdata, cpu_stall, cpu_err, mem_req, mem_we, mem_addr, mem_wdata,
        input  dbg_state
    );
endinterface

// File: rtl/stump_biu.sv
// Bus interface unit: registers a core access, holds it on the memory bus until acked,
// then releases the core for one cycle. Optional watchdog enabled by STUMP_BIU_TIMEOUT_EN.
module stump_biu #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    stump_biu_if.master bus
);
    // Handshake: mem_req rises the cycle after a core request and stays high with
    // stable mem_we/addr/wdata until a cycle where mem_ack=1; that cycle completes
    // the access. mem_ack is ignored in any cycle where the BIU is not in REQ.
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              cpu_req;

    assign cpu_req = bus.cpu_ren | bus.cpu_wen;

`ifdef STUMP_BIU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             err_q, err_d;
    assign cnt_inc = cnt_q + 1'b1;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
`ifdef STUMP_BIU_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    mem_addr_d  = bus.cpu_addr;
                    mem_wdata_d = bus.cpu_wdata;
                    mem_we_d    = bus.cpu_wen;
                    mem_req_d   = 1'b1;
                    state_d     = REQ;
`ifdef STUMP_BIU_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            REQ: begin
                // Ack takes priority over a watchdog expiry in the same cycle.
                if (bus.mem_ack) begin
                    if (!mem_we_q) cpu_rdata_d = bus.mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                end
`ifdef STUMP_BIU_TIMEOUT_EN
                else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(TIMEOUT)) begin
                        mem_req_d   = 1'b0;
                        cpu_rdata_d = '1;
                        err_d       = 1'b1;
                        state_d     = DONE;
                    end
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
`ifdef STUMP_BIU_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
`ifdef STUMP_BIU_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign bus.cpu_stall = ((state_q == IDLE) & cpu_req) | (state_q == REQ);
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dbg_state = state_q;
`ifdef STUMP_BIU_TIMEOUT_EN
    assign bus.cpu_err   = err_q;
`else
    assign bus.cpu_err   = 1'b0;
`endif
endmodule

// File: tb/tb_stump_biu.sv
// Directed testbench for stump_biu: zero/multi-wait accesses, ren&wen, spurious ack,
// watchdog (or indefinite wait without STUMP_BIU_TIMEOUT_EN) and mid-access reset.
module tb_stump_biu;
    logic clk;
    logic rst;
    logic ack_comb;
    logic ack_drv;
    int   checks;
    int   failures;
    int   cnt;

    stump_biu_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    stump_biu #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory model: either zero-wait (ack follows mem_req) or bench-driven ack.
    assign bus.mem_ack = ack_comb ? bus.mem_req : ack_drv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish, got timeout want finish");
        $fatal(1, "bench timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_idle();
        bus.cpu_ren = 1'b0;
        bus.cpu_wen = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        ack_comb  = 1'b0;
        ack_drv   = 1'b0;
        bus.cpu_ren   = 1'b0;
        bus.cpu_wen   = 1'b0;
        bus.cpu_addr  = 16'h0000;
        bus.cpu_wdata = 16'h0000;
        bus.mem_rdata = 16'h0000;

        // Reset state
        tick(); tick();
        check_eq("rst_state", {30'd0, bus.dbg_state}, 32'd0);
        check_eq("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        check_eq("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        check_eq("rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
        check_eq("rst_mem_wdata", {16'd0, bus.mem_wdata}, 32'd0);
        check_eq("rst_cpu_rdata", {16'd0, bus.cpu_rdata}, 32'd0);
        check_eq("rst_cpu_err", {31'd0, bus.cpu_err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check_eq("idle_stall", {31'd0, bus.cpu_stall}, 32'd0);

        // Zero-wait read at 0x0040, memory returns 0x1234
        ack_comb = 1'b1;
        bus.mem_rdata = 16'h1234;
        bus.cpu_ren  = 1'b1;
        bus.cpu_addr = 16'h0040;
        settle();
        check_eq("zw_stall_c0", {31'd0, bus.cpu_stall}, 32'd1);
        tick();
        check_eq("zw_req_c1", {31'd0, bus.mem_req}, 32'd1);
        check_eq("zw_we_c1", {31'd0, bus.mem_we}, 32'd0);
        check_eq("zw_addr_c1", {16'd0, bus.mem_addr}, 32'h0040);
        check_eq("zw_stall_c1", {31'd0, bus.cpu_stall}, 32'd1);
        tick();
        check_eq("zw_stall_c2", {31'd0, bus.cpu_stall}, 32'd0);
        check_eq("zw_rdata_c2", {16'd0, bus.cpu_rdata}, 32'h1234);
        check_eq("zw_req_c2", {31'd0, bus.mem_req}, 32'd0);
        drive_idle();
        tick();
        check_eq("zw_idle_state", {30'd0, bus.dbg_state}, 32'd0);
        ack_comb = 1'b0;

        // Three-wait-state write 0xBEEF to 0x0100, ack in cycle 4
        bus.mem_rdata = 16'h7777;
        bus.cpu_wen   = 1'b1;
        bus.cpu_addr  = 16'h0100;
        bus.cpu_wdata = 16'hBEEF;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check_eq($sformatf("wr_req_c%0d", c), {31'd0, bus.mem_req}, 32'd1);
            check_eq($sformatf("wr_bus_c%0d", c), {bus.mem_we, 7'd0, bus.mem_addr[7:0], bus.mem_wdata},
                     {1'b1, 7'd0, 8'h00, 16'hBEEF});
            check_eq($sformatf("wr_addr_c%0d", c), {16'd0, bus.mem_addr}, 32'h0100);
            check_eq($sformatf("wr_stall_c%0d", c), {31'd0, bus.cpu_stall}, 32'd1);
        end
        ack_drv = 1'b1;
        tick();
        check_eq("wr_stall_c5", {31'd0, bus.cpu_stall}, 32'd0);
        check_eq("wr_rdata_kept", {16'd0, bus.cpu_rdata}, 32'h1234);
        ack_drv = 1'b0;
        drive_idle();
        tick();

        // ren & wen together: write wins
        bus.cpu_ren   = 1'b1;
        bus.cpu_wen   = 1'b1;
        bus.cpu_addr  = 16'h0022;
        bus.cpu_wdata = 16'h5A5A;
        tick();
        check_eq("rw_we", {31'd0, bus.mem_we}, 32'd1);
        check_eq("rw_wdata", {16'd0, bus.mem_wdata}, 32'h5A5A);
        ack_drv = 1'b1;
        tick();
        check_eq("rw_done_stall", {31'd0, bus.cpu_stall}, 32'd0);
        check_eq("rw_rdata_kept", {16'd0, bus.cpu_rdata}, 32'h1234);
        drive_idle();
        ack_drv = 1'b1;
        bus.mem_rdata = 16'hDEAD;

        // Spurious ack in IDLE
        tick();
        tick();
        check_eq("sp_state", {30'd0, bus.dbg_state}, 32'd0);
        check_eq("sp_req", {31'd0, bus.mem_req}, 32'd0);
        check_eq("sp_rdata", {16'd0, bus.cpu_rdata}, 32'h1234);
        ack_drv = 1'b0;

        // Access never acknowledged
        bus.cpu_ren  = 1'b1;
        bus.cpu_addr = 16'h0300;
        bus.mem_rdata = 16'hC0DE;
`ifdef STUMP_BIU_TIMEOUT_EN
        cnt = 0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (bus.mem_req && bus.cpu_stall && !bus.cpu_err) cnt++;
        end
        check_eq("to_req_cycles", cnt, 32'd15);
        tick();
        check_eq("to_req_low", {31'd0, bus.mem_req}, 32'd0);
        check_eq("to_err", {31'd0, bus.cpu_err}, 32'd1);
        check_eq("to_rdata", {16'd0, bus.cpu_rdata}, 32'hFFFF);
        check_eq("to_stall", {31'd0, bus.cpu_stall}, 32'd0);
        drive_idle();
        tick();
        check_eq("to_err_pulse", {31'd0, bus.cpu_err}, 32'd0);
`else
        cnt = 0;
        for (int c = 1; c <= 120; c++) begin
            tick();
            if (bus.mem_req && bus.cpu_stall && !bus.cpu_err) cnt++;
        end
        check_eq("nto_stall_cycles", cnt, 32'd120);
        ack_drv = 1'b1;
        tick();
        check_eq("nto_err", {31'd0, bus.cpu_err}, 32'd0);
        check_eq("nto_rdata", {16'd0, bus.cpu_rdata}, 32'hC0DE);
        check_eq("nto_stall", {31'd0, bus.cpu_stall}, 32'd0);
        ack_drv = 1'b0;
        drive_idle();
        tick();
`endif

        // Reset mid-access: outputs drop with no clock edge
        bus.cpu_ren  = 1'b1;
        bus.cpu_addr = 16'h0444;
        tick();
        tick();
        check_eq("mr_req_before", {31'd0, bus.mem_req}, 32'd1);
        rst = 1'b0;
        drive_idle();
        settle();
        check_eq("mr_req_async", {31'd0, bus.mem_req}, 32'd0);
        check_eq("mr_stall_async", {31'd0, bus.cpu_stall}, 32'd0);
        check_eq("mr_addr_async", {16'd0, bus.mem_addr}, 32'd0);
        check_eq("mr_err", {31'd0, bus.cpu_err}, 32'd0);
        tick();
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Normal read after reset, one wait state
        bus.mem_rdata = 16'h0F0F;
        bus.cpu_ren   = 1'b1;
        bus.cpu_addr  = 16'h0050;
        tick();
        check_eq("pr_req", {31'd0, bus.mem_req}, 32'd1);
        check_eq("pr_addr", {16'd0, bus.mem_addr}, 32'h0050);
        tick();
        ack_drv = 1'b1;
        tick();
        check_eq("pr_stall", {31'd0, bus.cpu_stall}, 32'd0);
        check_eq("pr_rdata", {16'd0, bus.cpu_rdata}, 32'h0F0F);
        check_eq("pr_err", {31'd0, bus.cpu_err}, 32'd0);
        ack_drv = 1'b0;
        drive_idle();
        tick();
        check_eq("pr_idle", {30'd0, bus.dbg_state}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stump_biu.md
# stump_biu

Parametrised bus interface unit placed between the Stump core's memory port and system memory. It adds a request/acknowledge handshake with a core stall, so the core can use memories with arbitrary wait states; the current core assumes single-cycle memory. It registers each core access, holds it on the memory bus until acknowledged, and releases the core for exactly one cycle when the access completes. An optional watchdog aborts accesses that are never acknowledged.

## Interface
Parameters:
- DATA_W, 16, data bus width in bits
- ADDR_W, 16, address bus width in bits
- TIMEOUT, 15, cycles in REQ without ack before abort (≥1; used only with watchdog)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- cpu_ren  input  1  core read request
- cpu_wen  input  1  core write request
- cpu_addr  input  ADDR_W  core address
- cpu_wdata  input  DATA_W  core write data
- cpu_rdata  output  DATA_W  read data to core, valid while cpu_stall=0 in DONE
- cpu_stall  output  1  hold core (clock-enable low) while access outstanding
- cpu_err  output  1  one-cycle pulse: access aborted by watchdog
- mem_req  output  1  memory request, registered
- mem_we  output  1  1 = write, 0 = read, registered
- mem_addr  output  ADDR_W  registered address
- mem_wdata  output  DATA_W  registered write data
- mem_rdata  input  DATA_W  memory read data, sampled when mem_ack=1
- mem_ack  input  1  memory acknowledge; may be combinational from mem_req

## Operation
- States: IDLE, REQ, DONE. Reset → IDLE.
- IDLE: if cpu_ren|cpu_wen, latch cpu_addr, cpu_wdata, and mem_we=cpu_wen, set mem_req=1, clear timeout counter, and go to REQ. cpu_ren and cpu_wen both high → write performed.
- REQ: mem_req held at 1, outputs stable. On mem_ack: capture mem_rdata into cpu_rdata for reads (writes leave cpu_rdata unchanged), clear mem_req, go to DONE.
- DONE: exactly one cycle, then IDLE. Any core request still present in IDLE afterwards is a new access.
- cpu_stall (combinational) = (state==IDLE & (cpu_ren|cpu_wen)) | state==REQ. It is 0 in DONE and in IDLE with no request.
- Core must hold request, address and data stable while cpu_stall=1.
- mem_ack outside REQ is ignored.
- Reset values: state IDLE; mem_req, mem_we, cpu_err 0; mem_addr, mem_wdata, cpu_rdata all zero; timeout counter 0.
- Reset asserted mid-access: mem_req drops immediately (asynchronously) and the access is abandoned without an error.

## Timing
- Request seen at edge 0 (IDLE); mem_req=1 from cycle 1.
- Ack at cycle k≥1 → DONE at cycle k+1. cpu_stall is low only in cycle k+1.
- Minimum stall: 2 cycles (zero-wait memory). Each extra wait state adds 1.
- Back-to-back accesses: one IDLE cycle between DONE and the next mem_req, so a sustained access occurs every k+2 cycles.

## Configuration
- STUMP_BIU_TIMEOUT_EN defined: the counter (width clog2(TIMEOUT+1)) increments each REQ cycle without ack. When it reaches TIMEOUT, the block clears mem_req, sets cpu_rdata to all ones, pulses cpu_err in DONE, and returns to IDLE. If ack arrives in the same cycle as the timeout, the ack wins and no error is raised.
- Undefined: no counter; REQ waits indefinitely; cpu_err tied to 0.

## Test plan
- Zero-wait read: mem_ack tied to mem_req, mem_rdata=16'h1234, cpu_ren at addr 16'h0040 → mem_req cycle 1, stall cycles 0–1, cpu_rdata=16'h1234 with stall=0 in cycle 2.
- Three wait states write: cpu_wen, addr 16'h0100, wdata 16'hBEEF, ack in cycle 4 → mem_we=1, mem_addr/mem_wdata stable cycles 1–4, stall low cycle 5 only, cpu_rdata unchanged.
- Simultaneous cpu_ren&cpu_wen → mem_we=1; spurious mem_ack in IDLE → no state change, no capture.
- Timeout (macro on, TIMEOUT=15, no ack) → mem_req low after 15 REQ cycles, cpu_err=1 for one cycle, cpu_rdata=16'hFFFF; repeat with macro off → stall held for 100+ cycles, cpu_err=0.
- rst pulled low during REQ → mem_req, cpu_stall 0 with no clock edge; after release, a new read completes normally.
